conv_result_gather: RTL

- Receiver end of the convolution datapath: accepts the per-window scalar results that conv units emit, one element per handshake, in raster order (row-major over output positions).
- Assembles them into the flat single-layer output map consumed by the next layer.
- Presents the completed map with a valid/ready handshake.
- Optionally applies ReLU on capture.

---
 rtl/conv_result_gather_if.sv | 25 ++
 rtl/conv_result_gather.sv | 119 +++++++++++
 2 files changed

// File: rtl/conv_result_gather_if.sv
// Handshake bundle between the conv-unit result stream, the gather block and
// the consumer of the assembled output map.
interface conv_result_gather_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 784
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [0:N*DATA_WIDTH-1] res;
  logic                    res_valid;
  logic                    res_ready;

  // Producer of results and consumer of the frame.
  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res, res_valid
  );

  // The gather block.
  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res, res_valid
  );
endinterface

// File: rtl/conv_result_gather.sv
// Collects per-window conv results in raster order into a flat output map and
// hands the finished map downstream with a valid/ready handshake. Optional ReLU
// zeroes negative elements as they are captured.
//
// state   | meaning
// IDLE    | waiting for start; res holds the last frame's contents
// COLLECT | accepting one element per handshake, row/col counters advance
// DONE    | full map presented on res with res_valid until res_ready
module conv_result_gather #(
  parameter int DATA_WIDTH = 32,
  parameter int FLOAT_MODE = 1,
  parameter int RELU_EN    = 0,
  parameter int S          = 5,
  parameter int H          = 32,
  parameter int W          = 32,
  localparam int OH = H - S + 1,
  localparam int OW = W - S + 1,
  localparam int N  = OH * OW,
  localparam int RW = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  conv_result_gather_if.slave bus,
  output logic                busy,
  output logic [RW-1:0]       row_idx,
  output logic [CW-1:0]       col_idx
);

  localparam int IW = (N * DATA_WIDTH > 1) ? $clog2(N * DATA_WIDTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state;
  logic                  neg;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [IW-1:0]         wr_base;

  // Sign test: float sign bit or two's-complement negative (same bit, both views).
  always_comb begin
    neg = (FLOAT_MODE != 0) ? bus.in_data[DATA_WIDTH-1]
                            : ($signed(bus.in_data) < $signed(DATA_WIDTH'(0)));
    cap_data = ((RELU_EN != 0) && neg) ? '0 : bus.in_data;
    wr_base  = IW'((32'(row_idx) * OW + 32'(col_idx)) * DATA_WIDTH);
  end

  // Frame FSM with registered handshake outputs, index counters and result store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      busy          <= 1'b0;
      row_idx       <= '0;
      col_idx       <= '0;
      bus.res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= COLLECT;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            row_idx      <= '0;
            col_idx      <= '0;
          end
        end
        COLLECT: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.res[wr_base +: DATA_WIDTH] <= cap_data;
            if (col_idx == COL_LAST) begin
              col_idx <= '0;
              if (row_idx == ROW_LAST) begin
                row_idx       <= '0;
                state         <= DONE;
                bus.in_ready  <= 1'b0;
                busy          <= 1'b0;
                bus.res_valid <= 1'b1;
              end else begin
                row_idx <= row_idx + 1'b1;
              end
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            // Back-to-back frames skip IDLE when start coincides with release.
            if (start) begin
              state        <= COLLECT;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
              row_idx      <= '0;
              col_idx      <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.res_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
